// File: rtl/parity_check_gen.sv
// Serial Rx data accumulator with configurable parity check and error status.
// Optional PARCHK_ERR_CNT_EN adds a saturating parity-error counter.
module parity_check_gen #(
    parameter int MAX_DATA_W = 8,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk_pg,
    input  logic                  rst_pg,
    input  logic                  frame_start_pg,
    input  logic                  bit_vld_pg,
    input  logic                  sampled_bit_pg,
    input  logic                  par_en_pg,
    input  logic [1:0]            par_mode_pg,
    input  logic [4:0]            data_len_pg,
    input  logic                  abort_pg,
    input  logic                  clr_err_pg,
    output logic [MAX_DATA_W-1:0] p_data_pg,
    output logic                  data_vld_pg,
    output logic                  par_error_pg,
    output logic                  par_err_sticky_pg,
    output logic [ERR_CNT_W-1:0]  err_cnt_pg,
    output logic                  busy_pg
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, DONE} state_t;

    state_t                state_q, state_d;
    logic [MAX_DATA_W-1:0] data_q;
    logic                  acc_q;
    logic [4:0]            cnt_q;
    logic [4:0]            len_q;
    logic [4:0]            eff_len;
    logic                  par_en_q;
    logic [1:0]            mode_q;
    logic                  mism_q;
    logic                  exp_par;
    logic                  last_bit;
    logic                  log_err;

    assign eff_len = (data_len_pg == 5'd0 || data_len_pg > 5'(MAX_DATA_W))
                   ? 5'(MAX_DATA_W) : data_len_pg;
    assign last_bit = (cnt_q == len_q - 5'd1);

    always_comb begin
        exp_par = 1'b0;
        unique case (mode_q)
            2'b00: exp_par = acc_q;
            2'b01: exp_par = ~acc_q;
            2'b10: exp_par = 1'b1;
            2'b11: exp_par = 1'b0;
        endcase
    end

    always_ff @(posedge clk_pg or posedge rst_pg) begin
        if (rst_pg) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort_pg) begin
            state_d = IDLE;
        end else if (frame_start_pg) begin
            state_d = DATA;
        end else begin
            unique case (state_q)
                IDLE:    state_d = IDLE;
                DATA:    if (bit_vld_pg && last_bit)
                             state_d = par_en_q ? PARITY : DONE;
                PARITY:  if (bit_vld_pg) state_d = DONE;
                DONE:    state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        data_vld_pg  = (state_q == DONE);
        par_error_pg = (state_q == DONE) && mism_q;
        busy_pg      = (state_q == DATA) || (state_q == PARITY);
    end

    // Config is captured at frame start so mid-frame changes cannot corrupt it.
    always_ff @(posedge clk_pg or posedge rst_pg) begin
        if (rst_pg) begin
            data_q   <= '0;
            acc_q    <= 1'b0;
            cnt_q    <= 5'd0;
            len_q    <= 5'd0;
            par_en_q <= 1'b0;
            mode_q   <= 2'b00;
            mism_q   <= 1'b0;
        end else if (abort_pg) begin
            mism_q <= 1'b0;
        end else if (frame_start_pg) begin
            data_q   <= '0;
            acc_q    <= 1'b0;
            cnt_q    <= 5'd0;
            len_q    <= eff_len;
            par_en_q <= par_en_pg;
            mode_q   <= par_mode_pg;
            mism_q   <= 1'b0;
        end else if (bit_vld_pg && state_q == DATA) begin
            data_q <= data_q
                    | ({{(MAX_DATA_W-1){1'b0}}, sampled_bit_pg} << cnt_q);
            acc_q  <= acc_q ^ sampled_bit_pg;
            cnt_q  <= cnt_q + 5'd1;
        end else if (bit_vld_pg && state_q == PARITY) begin
            mism_q <= (sampled_bit_pg != exp_par);
        end
    end

    assign p_data_pg = data_q;
    assign log_err   = (state_q == DONE) && mism_q;

    always_ff @(posedge clk_pg or posedge rst_pg) begin
        if (rst_pg)          par_err_sticky_pg <= 1'b0;
        else if (log_err)    par_err_sticky_pg <= 1'b1;
        else if (clr_err_pg) par_err_sticky_pg <= 1'b0;
    end

`ifdef PARCHK_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // A new error outranks a coincident clear, leaving a count of one.
    always_ff @(posedge clk_pg or posedge rst_pg) begin
        if (rst_pg) begin
            err_cnt_q <= '0;
        end else if (log_err) begin
            if (clr_err_pg)
                err_cnt_q <= ERR_CNT_W'(1);
            else if (err_cnt_q != '1)
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end else if (clr_err_pg) begin
            err_cnt_q <= '0;
        end
    end

    assign err_cnt_pg = err_cnt_q;
`else
    assign err_cnt_pg = '0;
`endif

endmodule

// File: tb/tb_parity_check_gen.sv
// Directed bench for parity_check_gen.
// Counter expectations follow PARCHK_ERR_CNT_EN.
module tb_parity_check_gen;

`ifdef PARCHK_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk_pg = 1'b0;
    logic       rst_pg = 1'b1;
    logic       frame_start_pg = 1'b0;
    logic       bit_vld_pg = 1'b0;
    logic       sampled_bit_pg = 1'b0;
    logic       par_en_pg = 1'b0;
    logic [1:0] par_mode_pg = 2'b00;
    logic [4:0] data_len_pg = 5'd8;
    logic       abort_pg = 1'b0;
    logic       clr_err_pg = 1'b0;
    logic [7:0] p_data_pg;
    logic       data_vld_pg;
    logic       par_error_pg;
    logic       par_err_sticky_pg;
    logic [7:0] err_cnt_pg;
    logic       busy_pg;

    int checks = 0;
    int errors = 0;

    parity_check_gen #(.MAX_DATA_W(8), .ERR_CNT_W(8)) dut (
        .clk_pg           (clk_pg),
        .rst_pg           (rst_pg),
        .frame_start_pg   (frame_start_pg),
        .bit_vld_pg       (bit_vld_pg),
        .sampled_bit_pg   (sampled_bit_pg),
        .par_en_pg        (par_en_pg),
        .par_mode_pg      (par_mode_pg),
        .data_len_pg      (data_len_pg),
        .abort_pg         (abort_pg),
        .clr_err_pg       (clr_err_pg),
        .p_data_pg        (p_data_pg),
        .data_vld_pg      (data_vld_pg),
        .par_error_pg     (par_error_pg),
        .par_err_sticky_pg(par_err_sticky_pg),
        .err_cnt_pg       (err_cnt_pg),
        .busy_pg          (busy_pg)
    );

    always #5 clk_pg = ~clk_pg;

    task automatic tick;
        @(posedge clk_pg);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic en, input logic [1:0] mode,
                         input logic [4:0] len);
        frame_start_pg = 1'b1;
        par_en_pg      = en;
        par_mode_pg    = mode;
        data_len_pg    = len;
        tick();
        frame_start_pg = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_vld_pg     = 1'b1;
        sampled_bit_pg = b;
        tick();
        bit_vld_pg     = 1'b0;
    endtask

    // Leaves the bench one cycle after the final bit, i.e. in the DONE cycle.
    task automatic send_frame(input logic [15:0] data, input int nbits,
                              input logic [4:0] cfg_len, input logic en,
                              input logic [1:0] mode, input logic pbit);
        start(en, mode, cfg_len);
        for (int i = 0; i < nbits; i++) send_bit(data[i]);
        if (en) send_bit(pbit);
    endtask

    initial begin
        tick();
        tick();
        check("rst_p_data", p_data_pg, 0);
        check("rst_vld", data_vld_pg, 0);
        check("rst_perr", par_error_pg, 0);
        check("rst_sticky", par_err_sticky_pg, 0);
        check("rst_cnt", err_cnt_pg, 0);
        check("rst_busy", busy_pg, 0);
        rst_pg = 1'b0;
        tick();

        // even, 0xA5 has four ones -> parity bit 0 is correct
        start(1'b1, 2'b00, 5'd8);
        check("busy_data", busy_pg, 1);
        for (int i = 0; i < 8; i++) send_bit(((8'hA5 >> i) & 8'h1) != 0);
        check("busy_par", busy_pg, 1);
        check("no_vld_early", data_vld_pg, 0);
        send_bit(1'b0);
        check("even_vld", data_vld_pg, 1);
        check("even_data", p_data_pg, 8'hA5);
        check("even_perr", par_error_pg, 0);
        check("done_busy", busy_pg, 0);
        tick();
        check("vld_pulse", data_vld_pg, 0);
        check("data_hold", p_data_pg, 8'hA5);

        // odd with parity bit 0 -> mismatch
        send_frame(16'h00A5, 8, 5'd8, 1'b1, 2'b01, 1'b0);
        check("odd_vld", data_vld_pg, 1);
        check("odd_perr", par_error_pg, 1);
        tick();
        check("perr_pulse", par_error_pg, 0);
        check("odd_sticky", par_err_sticky_pg, 1);
        check("odd_cnt", err_cnt_pg, CNT_ON ? 1 : 0);

        // five bits, no parity: 1,0,1,1,0 -> 0x0D
        send_frame(16'h000D, 5, 5'd5, 1'b0, 2'b00, 1'b0);
        check("np_vld", data_vld_pg, 1);
        check("np_data", p_data_pg, 8'h0D);
        check("np_perr", par_error_pg, 0);
        tick();

        // mark expects 1, space expects 0
        send_frame(16'h007F, 7, 5'd7, 1'b1, 2'b10, 1'b0);
        check("mark_data", p_data_pg, 8'h7F);
        check("mark_perr", par_error_pg, 1);
        tick();
        send_frame(16'h007F, 7, 5'd7, 1'b1, 2'b11, 1'b0);
        check("space_vld", data_vld_pg, 1);
        check("space_perr", par_error_pg, 0);
        tick();
        check("cnt_two", err_cnt_pg, CNT_ON ? 2 : 0);

        clr_err_pg = 1'b1;
        tick();
        clr_err_pg = 1'b0;
        check("clr_sticky", par_err_sticky_pg, 0);
        check("clr_cnt", err_cnt_pg, 0);

        // abort after three bits, then a clean 0x3C frame
        start(1'b1, 2'b00, 5'd8);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        abort_pg = 1'b1;
        tick();
        abort_pg = 1'b0;
        check("abort_busy", busy_pg, 0);
        check("abort_vld", data_vld_pg, 0);
        send_bit(1'b1);
        check("idle_ignores", busy_pg, 0);
        send_frame(16'h003C, 8, 5'd8, 1'b1, 2'b00, 1'b0);
        check("ab_vld", data_vld_pg, 1);
        check("ab_data", p_data_pg, 8'h3C);
        check("ab_perr", par_error_pg, 0);
        tick();
        check("ab_sticky", par_err_sticky_pg, 0);

        // restart mid-frame: partial frame dropped; 0x12 even ok
        start(1'b1, 2'b00, 5'd8);
        send_bit(1'b1);
        send_bit(1'b1);
        send_frame(16'h0012, 8, 5'd8, 1'b1, 2'b00, 1'b0);
        check("rs_data", p_data_pg, 8'h12);
        check("rs_perr", par_error_pg, 0);
        tick();

        // len 0 and len 20 both mean 8 bits
        send_frame(16'h0081, 8, 5'd0, 1'b1, 2'b00, 1'b0);
        check("len0_vld", data_vld_pg, 1);
        check("len0_data", p_data_pg, 8'h81);
        tick();
        send_frame(16'h00F0, 8, 5'd20, 1'b0, 2'b00, 1'b0);
        check("len20_vld", data_vld_pg, 1);
        check("len20_data", p_data_pg, 8'hF0);
        tick();

        // config latched: mid-frame changes are ignored
        start(1'b1, 2'b01, 5'd5);
        par_en_pg   = 1'b0;
        data_len_pg = 5'd8;
        par_mode_pg = 2'b00;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("latch_novld", data_vld_pg, 0);
        send_bit(1'b0);
        check("latch_vld", data_vld_pg, 1);
        check("latch_data", p_data_pg, 8'h1F);
        check("latch_perr", par_error_pg, 0);
        tick();

        // saturation: 256 bad mark frames
        for (int f = 0; f < 255; f++) begin
            send_frame(16'h0000, 5, 5'd5, 1'b1, 2'b10, 1'b0);
            tick();
        end
        check("cnt_255", err_cnt_pg, CNT_ON ? 8'hFF : 0);
        send_frame(16'h0000, 5, 5'd5, 1'b1, 2'b10, 1'b0);
        tick();
        check("cnt_sat", err_cnt_pg, CNT_ON ? 8'hFF : 0);
        check("sat_sticky", par_err_sticky_pg, 1);
        send_frame(16'h0000, 5, 5'd5, 1'b1, 2'b10, 1'b0);
        check("257_perr", par_error_pg, 1);
        clr_err_pg = 1'b1;
        tick();
        clr_err_pg = 1'b0;
        check("setwin_cnt", err_cnt_pg, CNT_ON ? 1 : 0);
        check("setwin_sticky", par_err_sticky_pg, 1);

        // asynchronous reset mid-frame
        start(1'b1, 2'b00, 5'd8);
        send_bit(1'b1);
        #2;
        rst_pg = 1'b1;
        #1;
        check("arst_busy", busy_pg, 0);
        check("arst_data", p_data_pg, 0);
        check("arst_sticky", par_err_sticky_pg, 0);
        check("arst_cnt", err_cnt_pg, 0);
        tick();
        check("arst_vld", data_vld_pg, 0);
        rst_pg = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_check_gen.md
Name: parity_check_gen

Overview:
Parametrised successor to the fixed 8-bit even/odd UART Rx parity checker. Accumulates data bits serially as they are sampled, then checks the parity bit against a running parity. Supports configurable data length and four parity modes (even/odd/mark/space) or no parity. Delivers the assembled byte with a validity strobe, plus pulse, sticky and counted parity-error status. Sits between the Rx data sampler and the Rx FSM/deserializer consumer.

Parameters:
MAX_DATA_W, 8, maximum data bits per frame (legal 5..16); width of p_data_pg
ERR_CNT_W, 8, width of saturating parity-error counter

Ports:
clk_pg  in  1  block clock
rst_pg  in  1  reset, asynchronous, active-high
frame_start_pg  in  1  one-cycle pulse: next bit_vld_pg carries data bit 0
bit_vld_pg  in  1  strobe: sampled_bit_pg valid this cycle
sampled_bit_pg  in  1  sampled serial bit
par_en_pg  in  1  1 = frame carries a parity bit
par_mode_pg  in  2  00 even, 01 odd, 10 mark (expect 1), 11 space (expect 0)
data_len_pg  in  5  data bits per frame; 0 or >MAX_DATA_W treated as MAX_DATA_W
abort_pg  in  1  discard current frame
clr_err_pg  in  1  clear sticky flag and counter
p_data_pg  out  MAX_DATA_W  assembled data, bit 0 = first received, unused MSBs 0
data_vld_pg  out  1  one-cycle pulse: p_data_pg/par_error_pg valid
par_error_pg  out  1  parity mismatch, qualified by data_vld_pg
par_err_sticky_pg  out  1  set on any parity error, held until clr_err_pg
err_cnt_pg  out  ERR_CNT_W  saturating parity-error count
busy_pg  out  1  high in DATA or PARITY

Behaviour:
- Reset: all outputs 0, state IDLE, running parity 0, bit counter 0.
- Config (par_en, par_mode, effective data_len) latched on frame_start_pg; changes mid-frame ignored.
- States: IDLE, DATA, PARITY, DONE.
- IDLE: bit_vld ignored; frame_start -> DATA, clear shift reg, parity acc, bit counter.
- DATA: each bit_vld stores bit at p_data[cnt], parity_acc ^= bit, cnt++. On the bit where cnt == len-1: -> PARITY if par_en, else -> DONE.
- PARITY: on bit_vld compare against expected: even = parity_acc, odd = ~parity_acc, mark = 1, space = 0. Mismatch registers error. -> DONE.
- DONE: exactly one cycle; data_vld_pg=1, par_error_pg=mismatch (always 0 when par_en=0). -> IDLE, or -> DATA if frame_start in same cycle.
- Latency: data_vld_pg asserts the cycle after the final bit_vld (parity bit, or last data bit if no parity).
- p_data_pg holds its value until the next frame_start; par_error_pg, data_vld_pg are single-cycle pulses.
- Sticky flag set in DONE on mismatch; counter increments there, saturates at all-ones, never wraps.
- Priority: abort_pg > frame_start_pg > bit_vld_pg. abort -> IDLE, no data_vld, no error logged.
- frame_start in DATA/PARITY: current frame dropped silently, new frame begins.
- clr_err same cycle as new error: set wins; sticky=1, counter=1.
- Reset mid-frame: immediate return to reset values, no output pulses.

Optional Feature:
PARCHK_ERR_CNT_EN: defined -> err_cnt_pg counter implemented as specified. Undefined -> no counter flops, err_cnt_pg tied 0; sticky flag and pulse unchanged.

Test Plan:
- len=8, even, data 0xA5 (LSB first), parity bit 0 -> next cycle data_vld=1, p_data=0xA5, par_error=0.
- len=8, odd, data 0xA5, parity bit 0 -> par_error=1, sticky=1, err_cnt=1.
- len=5, no parity, bits 1,0,1,1,0 -> data_vld after 5th bit_vld, p_data=0x0D, par_error=0.
- Mark mode, len=7, data 0x7F, parity bit 0 -> par_error=1; space mode parity bit 0 -> par_error=0.
- abort after 3 data bits, then full frame 0x3C even correct -> only one data_vld, p_data=0x3C, no error.
- 256 consecutive bad-parity frames with ERR_CNT_W=8 -> err_cnt saturates at 0xFF; clr_err coincident with 257th error -> err_cnt=1, sticky=1.
